// File: rtl/data_generator.sv
`default_nettype none
// ============================================================================
// Module      : data_generator
// Description : BIST data-background generator. Expands the 1-bit background
//               select from the BIST controller into the registered WIDTH-bit
//               write/compare word that drives the memory under test.
//               PATTERN=0 gives a solid background, PATTERN=1 a checkerboard;
//               any other PATTERN value behaves as solid.
// Ports       : clk     - system clock, rising-edge active
//               rst_n   - asynchronous active-low reset
//               data    - background select (0 = background, 1 = inverted)
//               data_in - generated data word, registered, WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module data_generator #(
    parameter int WIDTH   = 8,
    parameter int PATTERN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data,
    output logic [WIDTH-1:0] data_in
);

    // Odd-numbered bits set: the XOR term that turns a solid word into a
    // checkerboard with bit 0 carrying the select value itself.
    function automatic logic [WIDTH-1:0] odd_bit_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i % 2 == 1);
        end
        return m;
    endfunction

    // Background word for data=0. It doubles as the reset value, so the
    // checkerboard variant comes out of reset already showing f(0).
    localparam logic [WIDTH-1:0] C_BACKGROUND = (PATTERN == 1) ? odd_bit_mask() : '0;

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Inverting the whole background is the same as XORing with the
    // replicated select bit.
    always_comb begin
        word_d = {WIDTH{data}} ^ C_BACKGROUND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= C_BACKGROUND;
        end else begin
            word_q <= word_d;
        end
    end

    assign data_in = word_q;

endmodule
`default_nettype wire

// File: tb/tb_data_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_generator
// Description : Self-checking bench for data_generator. Several parameter
//               variants share clock, reset and select; a per-cycle compare
//               process checks each one against a behavioural model, and
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_generator;

    localparam int N = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic data  = 1'b1;

    logic [7:0]  q0;  // W8  P0
    logic [7:0]  q1;  // W8  P1
    logic [0:0]  q2;  // W1  P0
    logic [32:0] q3;  // W33 P0
    logic [0:0]  q4;  // W1  P1
    logic [7:0]  q5;  // W8  P2 (behaves as solid)

    data_generator #(.WIDTH(8),  .PATTERN(0)) u0 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q0));
    data_generator #(.WIDTH(8),  .PATTERN(1)) u1 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q1));
    data_generator #(.WIDTH(1),  .PATTERN(0)) u2 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q2));
    data_generator #(.WIDTH(33), .PATTERN(0)) u3 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q3));
    data_generator #(.WIDTH(1),  .PATTERN(1)) u4 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q4));
    data_generator #(.WIDTH(8),  .PATTERN(2)) u5 (.clk(clk), .rst_n(rst_n), .data(data), .data_in(q5));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [63:0] act [N];
    assign act[0] = 64'(q0);
    assign act[1] = 64'(q1);
    assign act[2] = 64'(q2);
    assign act[3] = 64'(q3);
    assign act[4] = 64'(q4);
    assign act[5] = 64'(q5);

    int    wid [N] = '{8, 8, 1, 33, 1, 8};
    int    pat [N] = '{0, 1, 0, 0, 1, 2};
    string nm  [N] = '{"w8p0", "w8p1", "w1p0", "w33p0", "w1p1", "w8p2"};

    // Word the spec's rules demand for a given width/pattern/select.
    function automatic logic [63:0] fword(input int w, input int p, input logic d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = (p == 1) ? (d ^ ((i % 2) == 1)) : d;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
        end
    endtask

    // Model: the last select value seen at a rising edge outside reset;
    // no value at all since reset means the reset word is expected.
    logic m_valid = 1'b0;
    logic m_d     = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b1;
            m_d     <= data;
        end
    end

    function automatic logic [63:0] model_exp(input int k);
        return m_valid ? fword(wid[k], pat[k], m_d) : fword(wid[k], pat[k], 1'b0);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < N; k++) begin
                check({"model_", nm[k]}, act[k], model_exp(k));
            end
        end
    end

    task automatic check_all_reset(input string tag);
        check({tag, "_w8p0"},  act[0], 64'h00);
        check({tag, "_w8p1"},  act[1], 64'hAA);
        check({tag, "_w1p0"},  act[2], 64'h0);
        check({tag, "_w33p0"}, act[3], 64'h0);
        check({tag, "_w1p1"},  act[4], 64'h0);
    endtask

    logic stream [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset asserted with data=1 and the clock running.
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        check_all_reset("rst_start");
        repeat (3) @(posedge clk);
        #4 check_all_reset("rst_hold");

        // Release with data=1: all-ones one edge later, of the right width.
        #2 rst_n = 1'b1;
        check("rel_before_edge_w8p0", act[0], 64'h00);
        @(posedge clk);
        #4;
        check("rel_w8p0",  act[0], 64'hFF);
        check("rel_w8p1",  act[1], 64'h55);
        check("rel_w1p0",  act[2], 64'h1);
        check("rel_w33p0", act[3], 64'h1_FFFF_FFFF);
        check("rel_w1p1",  act[4], 64'h1);
        check("rel_w8p2",  act[5], 64'hFF);
        #2;

        // Stream with one-cycle latency.
        for (int k = 0; k < 10; k++) begin
            data = stream[k];
            @(posedge clk);
            #4;
            check($sformatf("stream%0d_w8p0", k), act[0], stream[k] ? 64'hFF : 64'h00);
            check($sformatf("stream%0d_w8p1", k), act[1], stream[k] ? 64'h55 : 64'hAA);
            #2;
        end
        // Hold data=1 for 20 more cycles.
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #4 check($sformatf("hold%0d_w8p0", k), act[0], 64'hFF);
        end
        #2 data = 1'b0;
        @(posedge clk);
        #4 check("back_to_0_w8p0", act[0], 64'h00);

        // Glitch between edges must not reach the output.
        #1 data = 1'b1;
        #1 data = 1'b0;
        #1 check("glitch_w8p0", act[0], 64'h00);
        check("glitch_w8p1", act[1], 64'hAA);
        @(posedge clk);
        #4 check("glitch_after_edge_w8p0", act[0], 64'h00);

        // Asynchronous reset between edges while outputs show all-ones.
        #2 data = 1'b1;
        @(posedge clk);
        #2 check("pre_async_w8p0", act[0], 64'hFF);
        #1 rst_n = 1'b0;
        #1 check_all_reset("async_rst");
        repeat (2) @(posedge clk);
        #3 check_all_reset("async_hold");
        rst_n = 1'b1;
        #1 check_all_reset("async_rel_no_edge");
        @(posedge clk);
        #4 check("async_reload_w8p0", act[0], 64'hFF);
        #2;

        // Randomized select with occasional asynchronous reset pulses.
        for (int c = 0; c < 400; c++) begin
            data = 1'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                #1 rst_n = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #2 rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                #1 data = ~data;
                #1 data = ~data;
            end
            @(posedge clk);
            #6;
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
